uart_tx_buffered: RTL and testbench

Buffered 8N1 UART transmitter. It drives the board `tx` pin from the 25 MHz `clk` domain, under the same ~user_reset that resets the LCD chip.
- Debug and status producers push bytes through a req/ready handshake into a small FIFO.
- The block serialises queued bytes back-to-back at the configured baud rate.

---
 rtl/uart_tx_buffered.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO behind a req/ready handshake feeding a serialiser.
// Optional even parity bit after D7 when UART_TX_PARITY_EN is defined.
module uart_tx_buffered #(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            tx_req,
    input  logic [7:0]                      tx_data,
    output logic                            tx_ready,
    output logic                            uart_tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(DIV * STOP_BITS);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(DIV * STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          r_state;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit;
    logic [CW-1:0]   r_cnt;
    logic            r_tx;

    state_t          w_state_next;
    logic            w_push;
    logic            w_pop;
    logic            w_have;
    logic            w_bit_end;
    logic            w_stop_end;
    logic [2:0]      w_bit_inc;
    logic [2:0]      w_bit_next;
    logic [CW-1:0]   w_cnt_next;
    logic            w_tx_next;

    assign tx_ready   = !reset && (r_level != LW'(FIFO_DEPTH));
    assign w_push     = tx_req && tx_ready;
    assign w_have     = (r_level != '0);
    assign w_bit_end  = (r_cnt == BIT_LAST);
    assign w_stop_end = (r_cnt == STOP_LAST);
    assign w_bit_inc  = r_bit + 3'd1;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_cnt_next   = r_cnt + CW'(1);
        w_bit_next   = r_bit;
        w_tx_next    = r_tx;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                w_tx_next  = 1'b1;
                if (w_have) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                    w_tx_next    = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt_next   = '0;
                    w_bit_next   = 3'd0;
                    w_state_next = S_DATA;
                    w_tx_next    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_next = '0;
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
                        w_tx_next    = ^r_shift;
`else
                        w_state_next = S_STOP;
                        w_tx_next    = 1'b1;
`endif
                    end else begin
                        w_bit_next = w_bit_inc;
                        w_tx_next  = r_shift[w_bit_inc];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_cnt_next   = '0;
                    w_state_next = S_STOP;
                    w_tx_next    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                // The whole stop period is one counter run; back-to-back frames reload here.
                if (w_stop_end) begin
                    w_cnt_next = '0;
                    if (w_have) begin
                        w_pop        = 1'b1;
                        w_state_next = S_START;
                        w_tx_next    = 1'b0;
                    end else begin
                        w_state_next = S_IDLE;
                        w_tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_shift  <= '0;
            r_bit    <= '0;
            r_cnt    <= '0;
            r_tx     <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_bit   <= w_bit_next;
            r_cnt   <= w_cnt_next;
            r_tx    <= w_tx_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) begin
                r_shift  <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: storage is not reset; emptiness is tracked by the pointers and level alone.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= tx_data;
    end

    assign uart_tx    = r_tx;
    assign busy       = (r_state != S_IDLE) || w_have;
    assign fifo_level = r_level;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: a default-rate instance checked by a line monitor,
// plus a DIV=8, STOP_BITS=2 instance checked against a captured waveform.
module tb_uart_tx_buffered;

    localparam int DIV = 217;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NSYM   = 10 + PAR;
    localparam int FRAME  = NSYM * DIV;
    localparam int DIV6   = 8;
    localparam int NSYM6  = 11 + PAR;

    logic       clk;
    logic       reset;
    logic       tx_req, tx_req6;
    logic [7:0] tx_data, tx_data6;
    logic       tx_ready, tx_ready6;
    logic       uart_tx, uart_tx6;
    logic       busy, busy6;
    logic [2:0] fifo_level, fifo_level6;

    uart_tx_buffered u_dut (
        .clk        (clk),
        .reset      (reset),
        .tx_req     (tx_req),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    uart_tx_buffered #(.CLK_HZ(8), .BAUD(1), .FIFO_DEPTH(4), .STOP_BITS(2)) u_dut6 (
        .clk        (clk),
        .reset      (reset),
        .tx_req     (tx_req6),
        .tx_data    (tx_data6),
        .tx_ready   (tx_ready6),
        .uart_tx    (uart_tx6),
        .busy       (busy6),
        .fifo_level (fifo_level6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int frames = 0;
    int b2b    = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected line level for symbol sym of a frame carrying byte b.
    function automatic logic exp_level(input logic [7:0] b, input int sym);
        if (sym == 0) return 1'b0;
        if (sym <= 8) return b[sym-1];
        if (PAR == 1 && sym == 9) return ^b;
        return 1'b1;
    endfunction

    // Line monitor for the default instance: pops the scoreboard at each start bit.
    initial begin : monitor
        bit         in_frame;
        bit         prev;
        int         cnt;
        int         gap;
        int         errs;
        logic [7:0] cur;
        in_frame = 0; prev = 0; cnt = 0; gap = 0; errs = 0; cur = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_frame = 0;
                prev     = 0;
                exp_q.delete();
            end else begin
                if (!in_frame && uart_tx === 1'b0) begin
                    in_frame = 1; cnt = 0; errs = 0;
                    frames++;
                    if (prev && gap == 0) b2b++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 32'd1, 32'd0);
                        cur = '0;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end else if (!in_frame) begin
                    gap++;
                end
                if (in_frame) begin
                    if (uart_tx !== exp_level(cur, cnt / DIV)) errs++;
                    if (cnt == FRAME - 1) begin
                        check($sformatf("frame_%02h_bad_samples", cur), errs, 32'd0);
                        in_frame = 0; prev = 1; gap = 0;
                    end else begin
                        cnt++;
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        tx_req  = 1'b1;
        tx_data = b;
        if (!tx_ready) check("ready_low_level_full", fifo_level, 32'd4);
        while (!tx_ready && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        if (!tx_ready) begin
            check($sformatf("send_%02h_timeout", b), 32'd0, 32'd1);
        end else begin
            exp_q.push_back(b);
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after the accept edge N: busy stays high through N+len, drops at N+1+len.
    task automatic check_busy_fall(input string name, input int len);
        repeat (len) @(posedge clk);
        #1;
        check({name, "_busy_before_end"}, busy, 32'd1);
        @(posedge clk);
        #1;
        check({name, "_busy_fall"}, busy, 32'd0);
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_reached"}, busy, 32'd0);
    endtask

    logic trace [0:255];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int snap;
        int mism;
        logic [7:0] fb;
        reset = 1'b1; tx_req = 1'b1; tx_data = 8'hFF; tx_req6 = 1'b0; tx_data6 = 8'h00;

        // 1: reset held three cycles with a pending request
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_uart_tx", uart_tx, 32'd1);
            check("rst_tx_ready", tx_ready, 32'd0);
            check("rst_busy", busy, 32'd0);
            check("rst_fifo_level", fifo_level, 32'd0);
        end
        reset = 1'b0; tx_req = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("post_rst_no_frame", frames, 32'd0);
        check("post_rst_idle_line", uart_tx, 32'd1);
        check("post_rst_ready", tx_ready, 32'd1);

        // 2: single 0x55 frame, exact busy fall
        send(8'h55);
        tx_req = 1'b0;
        check("t2_level_after_accept", fifo_level, 32'd1);
        check("t2_busy_after_accept", busy, 32'd1);
        check_busy_fall("t2", FRAME);

        // 3: six bytes on a held request, FIFO fills, frames back to back
        b2b = 0;
        snap = frames;
        for (int i = 0; i < 6; i++) begin
            send(8'(i));
            if (i == 4) begin
                check("t3_level_full", fifo_level, 32'd4);
                check("t3_ready_low_full", tx_ready, 32'd0);
            end
        end
        tx_req = 1'b0;
        wait_idle("t3", 7 * FRAME);
        @(negedge clk);
        check("t3_frames", frames - snap, 32'd6);
        check("t3_back_to_back", b2b, 32'd5);
        check("t3_queue_drained", exp_q.size(), 32'd0);

        // 4: reset during data bit 3 of 0xA5 with two bytes queued
        send(8'hA5);
        send(8'h11);
        send(8'h22);
        tx_req = 1'b0;
        repeat (4 * DIV + 50) @(posedge clk);
        #1;
        check("t4_level_before_rst", fifo_level, 32'd2);
        check("t4_in_bit3", uart_tx, 32'd0);
        snap = frames;
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("t4_rst_uart_tx", uart_tx, 32'd1);
        check("t4_rst_level", fifo_level, 32'd0);
        check("t4_rst_busy", busy, 32'd0);
        check("t4_rst_ready", tx_ready, 32'd0);
        reset = 1'b0;
        repeat (3 * FRAME) @(posedge clk);
        #1;
        check("t4_no_more_frames", frames - snap, 32'd0);
        check("t4_line_idle", uart_tx, 32'd1);

        // 5: 0x07, parity bit 1 when enabled; frame length via busy
        send(8'h07);
        tx_req = 1'b0;
        check_busy_fall("t5", FRAME);
        @(negedge clk);
        check("t5_queue_drained", exp_q.size(), 32'd0);

        // 6: DIV=8, two stop bits, 0x80 then 0x01 back to back
        @(negedge clk);
        tx_req6 = 1'b1; tx_data6 = 8'h80;
        check("t6_ready_first", tx_ready6, 32'd1);
        @(posedge clk);
        #1;
        tx_data6 = 8'h01;
        check("t6_ready_second", tx_ready6, 32'd1);
        @(posedge clk);
        #1;
        tx_req6 = 1'b0;
        check("t6_level", fifo_level6, 32'd1);
        for (int i = 0; i < 2 * NSYM6 * DIV6 + DIV6; i++) begin
            trace[i] = uart_tx6;
            @(posedge clk);
            #1;
        end
        for (int f = 0; f < 2; f++) begin
            fb = (f == 0) ? 8'h80 : 8'h01;
            for (int s = 0; s < NSYM6; s++) begin
                mism = 0;
                for (int k = 0; k < DIV6; k++)
                    if (trace[(f * NSYM6 + s) * DIV6 + k] !== exp_level(fb, s)) mism++;
                check($sformatf("t6_f%0d_sym%0d", f, s), mism, 32'd0);
            end
        end
        mism = 0;
        for (int k = 0; k < DIV6; k++)
            if (trace[2 * NSYM6 * DIV6 + k] !== 1'b1) mism++;
        check("t6_idle_tail", mism, 32'd0);
        check("t6_busy_end", busy6, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
